// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and helpers for the nibble-serial subtractor.
// Holds the control state encoding, the nibble width and the counter sizing function.
package nibble_serial_subtractor_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count n distinct values.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// master drives operands and result-ready; slave is the subtractor itself.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero
  );
endinterface

// File: rtl/nibble_serial_subtractor_bla4_slice.sv
// Combinational 4-bit borrow-lookahead subtractor: d = x - y - bi, bo = borrow out.
// Every borrow is a flat sum of products over generate/propagate terms, not a ripple chain.
module bla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] bw;

  assign g = ~x & y;
  assign p = ~(x ^ y);

  assign bw[0] = bi;
  assign bw[1] = g[0] | (p[0] & bi);
  assign bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
  assign bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bi);
  assign bo    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);

  assign d = x ^ y ^ bw;
endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per cycle LSB first, borrow registered between cycles.
// Operands taken in IDLE, result held in DONE until out_ready; NIB cycles from accept to out_valid.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                     clk,
  input logic                     rst,
  nibble_serial_subtractor_if.slave bus
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_nx;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             bout_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [3:0]       x;
  logic [3:0]       y;
  logic [3:0]       d;
  logic             bo;

  assign x = a_q[cnt*NIBBLE_W +: NIBBLE_W];
  assign y = b_q[cnt*NIBBLE_W +: NIBBLE_W];

  bla4_slice u_slice (
    .x  (x),
    .y  (y),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  // Full result including the nibble being produced this cycle, so zero sees all bits.
  always_comb begin
    diff_nx = diff_q;
    diff_nx[cnt*NIBBLE_W +: NIBBLE_W] = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      cnt         <= '0;
      brw         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            brw        <= bus.bin;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          diff_q <= diff_nx;
          brw    <= bo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt         <= '0;
            bout_q      <= bo;
            zero_q      <= (diff_nx == '0);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Scoreboard bench: expected results queued on operand acceptance, popped by a monitor on each result handshake.
module tb_nibble_serial_subtractor;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_subtractor_if #(.WIDTH(W)) bus ();

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  res_t sb[$];
  res_t pend;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   acc_edge = 0;
  bit   acc_flag = 1'b0;
  bit   rand_rdy = 1'b0;

  // Reference: unsigned subtraction in W+1 bits; the extra bit is the borrow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    logic [W:0] t;
    res_t r;
    t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    r.diff = t[W-1:0];
    r.bout = t[W];
    r.zero = (t[W-1:0] == '0);
    return r;
  endfunction

  function automatic res_t mk(input logic [W-1:0] d, input logic bo, input logic z);
    res_t r;
    r.diff = d;
    r.bout = bo;
    r.zero = z;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic monitor();
    bit   prev_ov = 1'b0;
    bit   chk_ir  = 1'b0;
    res_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_ov = 1'b0;
        chk_ir  = 1'b0;
      end else begin
        if (chk_ir) begin
          chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
          chk("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
          chk_ir = 1'b0;
        end
        if (bus.in_valid && bus.in_ready) begin
          sb.push_back(pend);
          acc_edge = cyc + 1;
          acc_flag = 1'b1;
        end
        if (bus.out_valid && !prev_ov)
          chk("latency", 32'(cyc - acc_edge), 32'(NIB));
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result got diff=%0h expected no result", bus.diff);
          end else begin
            e = sb.pop_front();
            chk("diff", 32'(bus.diff), 32'(e.diff));
            chk("bout", 32'(bus.bout), 32'(e.bout));
            chk("zero", 32'(bus.zero), 32'(e.zero));
          end
          chk_ir = 1'b1;
        end
        prev_ov = bus.out_valid;
      end
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, input res_t exp);
    bit done;
    done         = 1'b0;
    pend         = exp;
    acc_flag     = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bi;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      cycle();
      if (acc_flag) done = 1'b1;
    end
    bus.in_valid = 1'b0;
    acc_flag     = 1'b0;
    // Scramble operands after acceptance; the result must not depend on them.
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.bin      = 1'($urandom);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=not accepted expected=accepted");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && sb.size() != 0; i++) cycle();
    cycle();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, hd;
    logic         rbi, hb, hz;
    bit           seen;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    fork
      monitor();
    join_none

    repeat (2) cycle();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    rst = 1'b0;
    cycle();

    send(16'h1234, 16'h0234, 1'b0, mk(16'h1000, 1'b0, 1'b0));
    drain();
    send(16'h0000, 16'h0001, 1'b0, mk(16'hFFFF, 1'b1, 1'b0));
    send(16'h8000, 16'h7FFF, 1'b1, mk(16'h0000, 1'b0, 1'b1));
    send(16'h1000, 16'h0001, 1'b1, mk(16'h0FFE, 1'b0, 1'b0));
    drain();

    // Backpressure: result must hold while new operands are offered.
    bus.out_ready = 1'b0;
    send(16'h5555, 16'h1111, 1'b0, mk(16'h4444, 1'b0, 1'b0));
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      cycle();
      if (bus.out_valid) seen = 1'b1;
    end
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    hd = bus.diff;
    hb = bus.bout;
    hz = bus.zero;
    chk("bp_held_diff_value", 32'(hd), 32'h4444);
    pend         = model(16'hAAAA, 16'h0F0F, 1'b1);
    bus.a        = 16'hAAAA;
    bus.b        = 16'h0F0F;
    bus.bin      = 1'b1;
    bus.in_valid = 1'b1;
    repeat (5) begin
      cycle();
      chk("bp_diff_stable", 32'(bus.diff), 32'(hd));
      chk("bp_bout_stable", 32'(bus.bout), 32'(hb));
      chk("bp_zero_stable", 32'(bus.zero), 32'(hz));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (NIB + 3) cycle();
    chk("bp_no_spurious_result", 32'(bus.out_valid), 32'd0);

    // Reset in the second BUSY cycle discards the operation.
    send(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0));
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb.delete();
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_diff", 32'(bus.diff), 32'd0);
    chk("midrst_bout", 32'(bus.bout), 32'd0);
    chk("midrst_zero", 32'(bus.zero), 32'd0);
    repeat (NIB + 2) cycle();
    chk("midrst_no_result", 32'(bus.out_valid), 32'd0);
    send(16'hFFFF, 16'hFFFF, 1'b0, mk(16'h0000, 1'b0, 1'b1));
    drain();

    // Random operations with random result backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? ra : W'($urandom);
      rbi = 1'($urandom);
      send(ra, rb, rbi, model(ra, rb, rbi));
    end
    drain();
    rand_rdy      = 1'b0;
    bus.out_ready = 1'b1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end
endmodule
